// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode constants, flag bundle and elaboration-time helpers
// for the single- and dual-clock FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_NORMAL = 0;
    localparam int unsigned FIFO_MODE_FWFT   = 1;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

    localparam fifo_flags_t FIFO_FLAGS_RST = '{
        full:   1'b0,
        afull:  1'b0,
        empty:  1'b1,
        aempty: 1'b1
    };

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned fifo_ptr_bits(input int unsigned abits);
        return abits + 32'd1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned abits);
        return 32'd1 << abits;
    endfunction

    function automatic bit fifo_thr_ok(input int unsigned thr,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (thr >= lo) && (thr <= hi);
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port RAM, DEPTH x DBITS, synchronous write and
// registered read; the read register holds unless re is asserted.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [DBITS-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ABITS);

    logic [DBITS-1:0] mem_q [DEPTH];
    logic [DBITS-1:0] rdata_d;
    logic [DBITS-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with fill level, almost-full/empty thresholds
// and synchronous flush. Sticky overflow/underflow flags under FIFO_SYNC_ERR_EN.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned SHOWAHEAD = FIFO_MODE_FWFT,
    parameter int unsigned ABITS     = 10,
    parameter int unsigned DBITS     = 16,
    parameter int unsigned FTHR      = 800,
    parameter int unsigned ETHR      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             wr_en,
    output logic             wr_full,
    output logic             wr_afull,
    input  logic             rd_en,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_empty,
    output logic             rd_aempty,
    output logic [ABITS:0]   count,
    output logic             err_ovf,
    output logic             err_udf,
    input  logic             err_clr
);

    localparam int unsigned PBITS = fifo_ptr_bits(ABITS);
    localparam int unsigned DEPTH = fifo_depth(ABITS);

    if (!fifo_thr_ok(FTHR, 1, DEPTH)) begin : g_bad_fthr
        $error("fifo_sync: FTHR must lie in 1..DEPTH");
    end
    if (!fifo_thr_ok(ETHR, 0, DEPTH - 1)) begin : g_bad_ethr
        $error("fifo_sync: ETHR must lie in 0..DEPTH-1");
    end
    if (SHOWAHEAD != FIFO_MODE_NORMAL && SHOWAHEAD != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_sync: SHOWAHEAD must be 0 or 1");
    end

    logic [PBITS-1:0] wptr_q, wptr_d;
    logic [PBITS-1:0] rptr_q, rptr_d;
    logic [PBITS-1:0] count_q, count_d;
    fifo_flags_t      flags_q, flags_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_udf_q, err_udf_d;

    logic             wr_acc;
    logic             rd_acc;
    logic             ram_we;
    logic             ram_re;
    logic [ABITS-1:0] ram_raddr;

    // Pointer, level and flag next-state.
    always_comb begin
        wr_acc = wr_en & ~flags_q.full;
        rd_acc = rd_en & ~flags_q.empty;
        ram_we = wr_acc & ~clr & ~rst;

        wptr_d = wptr_q + PBITS'(wr_acc);
        rptr_d = rptr_q + PBITS'(rd_acc);
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end

        count_d       = wptr_d - rptr_d;
        flags_d       = FIFO_FLAGS_RST;
        flags_d.full  = (wptr_d[PBITS-1] != rptr_d[PBITS-1]) &&
                        (wptr_d[ABITS-1:0] == rptr_d[ABITS-1:0]);
        flags_d.afull  = (count_d >= PBITS'(FTHR));
        flags_d.aempty = (count_d <= PBITS'(ETHR));

        // Show-ahead prefetches the new head; it is valid only once it was
        // written on an earlier edge, hence the compare against wptr_q.
        if (SHOWAHEAD == FIFO_MODE_FWFT) begin
            ram_raddr     = rptr_d[ABITS-1:0];
            flags_d.empty = (rptr_d == wptr_q) | clr;
            ram_re        = ~flags_d.empty;
        end else begin
            ram_raddr     = rptr_q[ABITS-1:0];
            flags_d.empty = (wptr_d == rptr_d);
            ram_re        = rd_acc & ~clr;
        end
    end

    // Sticky error flags; a clear in the same cycle beats a new set.
`ifdef FIFO_SYNC_ERR_EN
    always_comb begin
        err_ovf_d = err_ovf_q | (wr_en & flags_q.full & ~clr);
        err_udf_d = err_udf_q | (rd_en & flags_q.empty & ~clr);
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;

    always_comb begin
        err_ovf_d = 1'b0;
        err_udf_d = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            flags_q   <= FIFO_FLAGS_RST;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            flags_q   <= flags_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    fifo_sync_ram #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wptr_q[ABITS-1:0]),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

    assign wr_full   = flags_q.full;
    assign wr_afull  = flags_q.afull;
    assign rd_empty  = flags_q.empty;
    assign rd_aempty = flags_q.aempty;
    assign count     = count_q;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: drives both SHOWAHEAD variants in turn against a queue-based
// reference model; a negedge monitor scores every word the DUT hands out.
module tb_fifo_sync;

    localparam int ABITS = 4;
    localparam int DBITS = 16;
    localparam int DEPTH = 16;
    localparam int FTHR  = 12;
    localparam int ETHR  = 2;

`ifdef FIFO_SYNC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en   [2];
    logic             rd_en   [2];
    logic             clr     [2];
    logic             err_clr [2];
    logic [DBITS-1:0] wr_data [2];
    logic [DBITS-1:0] rd_data [2];
    logic             wr_full [2];
    logic             wr_afull[2];
    logic             rd_empty[2];
    logic             rd_aempty[2];
    logic             err_ovf [2];
    logic             err_udf [2];
    logic [ABITS:0]   count   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fifo_sync #(
            .SHOWAHEAD (g),
            .ABITS     (ABITS),
            .DBITS     (DBITS),
            .FTHR      (FTHR),
            .ETHR      (ETHR)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr[g]),
            .wr_data   (wr_data[g]),
            .wr_en     (wr_en[g]),
            .wr_full   (wr_full[g]),
            .wr_afull  (wr_afull[g]),
            .rd_en     (rd_en[g]),
            .rd_data   (rd_data[g]),
            .rd_empty  (rd_empty[g]),
            .rd_aempty (rd_aempty[g]),
            .count     (count[g]),
            .err_ovf   (err_ovf[g]),
            .err_udf   (err_udf[g]),
            .err_clr   (err_clr[g])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cur    = 0;
    int cyc    = 0;

    // Reference model: a word is visible at the show-ahead output once it was
    // written on an edge strictly before the current one.
    logic [DBITS-1:0] exp_q[$];
    int               st_q[$];
    int               m_cnt   = 0;
    bit               m_empty = 1'b1;
    bit               m_ovf   = 1'b0;
    bit               m_udf   = 1'b0;
    bit               pend    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL m%0d %s: got %0h expected %0h (cycle %0d)", cur, name, act, exp, cyc);
        end
    endtask

    task automatic score();
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL m%0d rd_data: got %0h with no word expected (cycle %0d)",
                     cur, rd_data[cur], cyc);
        end else begin
            check("rd_data", 32'(rd_data[cur]), 32'(exp_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            score();
        end
        if (!rst && !clr[cur] && rd_en[cur] && !rd_empty[cur]) begin
            if (cur == 1) begin
                score();
            end else begin
                pend = 1'b1;
            end
        end
    end

    task automatic flush_model();
        m_cnt = 0;
        st_q.delete();
        exp_q.delete();
    endtask

    task automatic tick(input bit w, input bit r, input logic [DBITS-1:0] d,
                        input bit c = 1'b0, input bit ec = 1'b0, input bit rs = 1'b0);
        bit wa;
        bit ra;
        bit full_b;
        wr_en[cur]   = w;
        rd_en[cur]   = r;
        wr_data[cur] = d;
        clr[cur]     = c;
        err_clr[cur] = ec;
        rst          = rs;
        @(posedge clk);
        cyc++;
        full_b = (m_cnt == DEPTH);
        if (rs) begin
            flush_model();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = !ec && (m_ovf || (w && full_b && !c));
            m_udf = !ec && (m_udf || (r && m_empty && !c));
            if (c) begin
                flush_model();
            end else begin
                wa = w && !full_b;
                ra = r && !m_empty;
                if (ra) void'(st_q.pop_front());
                if (wa) begin
                    st_q.push_back(cyc);
                    exp_q.push_back(d);
                end
                m_cnt = m_cnt + int'(wa) - int'(ra);
            end
        end
        m_empty = (cur == 1) ? (st_q.size() == 0 || st_q[0] >= cyc) : (m_cnt == 0);
        #1;
        check("count",     32'(count[cur]),     32'(m_cnt));
        check("wr_full",   32'(wr_full[cur]),   32'(m_cnt == DEPTH));
        check("wr_afull",  32'(wr_afull[cur]),  32'(m_cnt >= FTHR));
        check("rd_empty",  32'(rd_empty[cur]),  32'(m_empty));
        check("rd_aempty", 32'(rd_aempty[cur]), 32'(m_cnt <= ETHR));
        check("err_ovf",   32'(err_ovf[cur]),   32'(ERR_EN && m_ovf));
        check("err_udf",   32'(err_udf[cur]),   32'(ERR_EN && m_udf));
    endtask

    task automatic run_mode(input int m);
        int nxt;
        bit wh;
        bit w;
        bit r;
        cur = m;
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_rd_data", 32'(rd_data[cur]), 32'h0);

        for (int i = 1; i <= 16; i++) tick(1'b1, 1'b0, DBITS'(i));
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);

        tick(1'b1, 1'b0, 16'h00A5);
        tick(1'b0, 1'b0, '0);
        if (m == 1) check("fwft_head", 32'(rd_data[cur]), 32'h00A5);
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);

        nxt = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, DBITS'(nxt));
            nxt++;
        end
        tick(1'b0, 1'b0, '0);
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 1'b1, DBITS'(nxt));
            nxt++;
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, DBITS'(16'h0200 + i));
        tick(1'b1, 1'b1, 16'hDEAD);
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, '0);
        tick(1'b1, 1'b1, 16'h0BEE);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, DBITS'(16'h0300 + 10 * k + i));
            for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, '0);
        end

        for (int i = 0; i < 400; i++) begin
            wh = ((i / 100) % 2) == 0;
            w  = wh ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r  = wh ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick(w, r, DBITS'($urandom), $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, '0);

        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, DBITS'(16'h0100 + i));
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 16'hF1F1, 1'b1);
        check("clr_keeps_rd_data", 32'(rd_data[cur]), (m == 1) ? 32'h0101 : 32'h0100);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_clears_rd_data", 32'(rd_data[cur]), 32'h0);
        tick(1'b0, 1'b0, '0);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            wr_en[g]   = 1'b0;
            rd_en[g]   = 1'b0;
            clr[g]     = 1'b0;
            err_clr[g] = 1'b0;
            wr_data[g] = '0;
        end
        run_mode(0);
        run_mode(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
